// File: rtl/intcode_io_pkg.sv
// Shared constants for the memory-mapped Intcode I/O ports.
// Addresses, word width and status/control bit positions used by the port decoders.
package intcode_io_pkg;
    localparam int WORD_W = 32;

    localparam logic [31:0] INPUT_ADDR  = 32'hFFFF0000;
    localparam logic [31:0] OUTPUT_ADDR = 32'hFFFF0001;
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF0002;

    // Status read layout: count in the low half, sticky underflow above it.
    localparam int STATUS_COUNT_W       = 16;
    localparam int STATUS_UNDERFLOW_BIT = 16;

    // Control write bits at STATUS_ADDR.
    localparam int CTRL_CLEAR_UNDERFLOW_BIT = 0;
    localparam int CTRL_FLUSH_BIT           = 1;

    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/intcode_input_fifo_if.sv
// Producer stream plus CPU bus signals seen by the Intcode input port.
// Stream: a word transfers on a clock edge where in_valid & in_ready are both 1;
// the producer holds in_data stable while in_valid is 1 and in_ready is 0.
interface intcode_input_fifo_if;
    import intcode_io_pkg::*;

    logic  in_valid;
    word_t in_data;
    logic  in_ready;
    word_t address_bus;
    logic  ram_write;
    word_t bus_wdata;
    word_t bus_rdata;
    logic  bus_oe;

    modport master (
        output in_valid, in_data, address_bus, ram_write, bus_wdata,
        input  in_ready, bus_rdata, bus_oe
    );

    modport slave (
        input  in_valid, in_data, address_bus, ram_write, bus_wdata,
        output in_ready, bus_rdata, bus_oe
    );
endinterface

// File: rtl/intcode_sync_fifo.sv
// Single-clock FIFO: storage array, wrapping pointers, occupancy count and flush.
// push/pop are ignored when full/empty; flush overrides both.
module intcode_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly AW bits wide, so +1 wraps at DEPTH without a compare.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/intcode_input_fifo.sv
// Memory-mapped Intcode input port: buffers stream words and hands the head word to
// the CPU on reads of PORT_ADDR, consuming one word per completed read episode.
module intcode_input_fifo #(
    parameter int          DEPTH       = 16,
    parameter logic [31:0] PORT_ADDR   = intcode_io_pkg::INPUT_ADDR,
    parameter logic [31:0] STATUS_ADDR = intcode_io_pkg::STATUS_ADDR
) (
    input  logic                    clock,
    input  logic                    reset,
    intcode_input_fifo_if.slave     bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    underflow
);
    import intcode_io_pkg::*;

    logic  hit_d;
    logic  hit_s;
    logic  ctrl_write;
    logic  flush;
    logic  clear_underflow;
    logic  match_q;
    logic  complete;
    logic  push;
    logic  pop;
    logic  full;
    logic  empty;
    word_t head;
    word_t status_word;

    assign hit_d           = (bus.address_bus == PORT_ADDR) && !bus.ram_write;
    assign hit_s           = (bus.address_bus == STATUS_ADDR) && !bus.ram_write;
    assign ctrl_write      = (bus.address_bus == STATUS_ADDR) && bus.ram_write;
    assign flush           = ctrl_write && bus.bus_wdata[CTRL_FLUSH_BIT];
    assign clear_underflow = ctrl_write && bus.bus_wdata[CTRL_CLEAR_UNDERFLOW_BIT];

    // The CPU may hold the address for several cycles; the read is consumed only
    // on the first edge after the address moves away.
    assign complete     = match_q && !hit_d;
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = complete && !empty;

    intcode_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (bus.in_data),
        .pop   (pop),
        .flush (flush),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            match_q   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            match_q <= hit_d;
            // A fresh underflow event wins over a same-cycle clear.
            if (complete && empty) begin
                underflow <= 1'b1;
            end else if (clear_underflow) begin
                underflow <= 1'b0;
            end
        end
    end

    always_comb begin
        status_word                       = '0;
        status_word[STATUS_COUNT_W-1:0]   = STATUS_COUNT_W'(count);
        status_word[STATUS_UNDERFLOW_BIT] = underflow;
    end

    always_comb begin
        bus.bus_oe    = hit_d || hit_s;
        bus.bus_rdata = '0;
        if (hit_d) begin
            bus.bus_rdata = empty ? '0 : head;
        end else if (hit_s) begin
            bus.bus_rdata = status_word;
        end
    end
endmodule

// File: tb/tb_intcode_input_fifo.sv
// Randomized and directed checks of the Intcode input port against a queue-based model.
module tb_intcode_input_fifo;
    localparam int          DEPTH = 16;
    localparam logic [31:0] PORT  = 32'hFFFF0000;
    localparam logic [31:0] STAT  = 32'hFFFF0002;
    localparam logic [31:0] OTHER = 32'h0000_0100;

    logic       clock;
    logic       reset;
    logic [4:0] count;
    logic       underflow;

    intcode_input_fifo_if bus_if ();

    intcode_input_fifo #(
        .DEPTH       (DEPTH),
        .PORT_ADDR   (PORT),
        .STATUS_ADDR (STAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus_if),
        .count     (count),
        .underflow (underflow)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model: queue contents, sticky flag, and whether the last edge saw a data read
    logic [31:0] exp_q[$];
    bit          model_uf;
    bit          model_in_episode;
    int          n_checks;
    int          n_errors;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_uf         = 1'b0;
        model_in_episode = 1'b0;
    endtask

    task automatic check_all(input string tag);
        bit          rd_data;
        bit          rd_stat;
        logic [31:0] exp_rdata;
        rd_data   = (bus_if.address_bus == PORT) && !bus_if.ram_write;
        rd_stat   = (bus_if.address_bus == STAT) && !bus_if.ram_write;
        exp_rdata = 32'd0;
        if (rd_data) exp_rdata = (exp_q.size() == 0) ? 32'd0 : exp_q[0];
        else if (rd_stat) exp_rdata = (32'(model_uf) << 16) | 32'(exp_q.size());
        check_eq({tag, "_count"}, 32'(count), 32'(exp_q.size()));
        check_eq({tag, "_ready"}, 32'(bus_if.in_ready), 32'(exp_q.size() != DEPTH));
        check_eq({tag, "_oe"}, 32'(bus_if.bus_oe), 32'(rd_data || rd_stat));
        check_eq({tag, "_rdata"}, bus_if.bus_rdata, exp_rdata);
        check_eq({tag, "_underflow"}, 32'(underflow), 32'(model_uf));
    endtask

    // one clock edge; the model applies the rules to the inputs held across it
    task automatic tick();
        bit          rd_data;
        bit          finished;
        bit          accept;
        bit          ctrl;
        bit          was_empty;
        logic [31:0] word;
        rd_data   = (bus_if.address_bus == PORT) && !bus_if.ram_write;
        finished  = model_in_episode && !rd_data;
        accept    = bus_if.in_valid && (exp_q.size() != DEPTH);
        ctrl      = (bus_if.address_bus == STAT) && bus_if.ram_write;
        was_empty = (exp_q.size() == 0);
        word      = bus_if.in_data;
        @(posedge clock);
        #1;
        if (ctrl && bus_if.bus_wdata[0]) model_uf = 1'b0;
        if (finished) begin
            if (was_empty) model_uf = 1'b1;
            else void'(exp_q.pop_front());
        end
        if (accept) exp_q.push_back(word);
        if (ctrl && bus_if.bus_wdata[1]) exp_q.delete();
        model_in_episode = rd_data;
    endtask

    task automatic step(input string tag);
        #1;
        check_all(tag);
        tick();
    endtask

    // driver tasks
    task automatic drive_bus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        bus_if.address_bus = addr;
        bus_if.ram_write   = wr;
        bus_if.bus_wdata   = wdata;
    endtask

    task automatic drive_in(input logic valid, input logic [31:0] data);
        bus_if.in_valid = valid;
        bus_if.in_data  = data;
    endtask

    task automatic flush_fifo();
        drive_in(1'b0, 32'd0);
        drive_bus(STAT, 1'b1, 32'd3);
        step("flush");
        drive_bus(OTHER, 1'b0, 32'd0);
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            drive_in(1'b1, base + 32'(i));
            step("push");
        end
        drive_in(1'b0, 32'd0);
    endtask

    task automatic read_episode(input int hold);
        drive_bus(PORT, 1'b0, 32'd0);
        for (int i = 0; i < hold; i++) step("read");
        drive_bus(OTHER, 1'b0, 32'd0);
        step("leave");
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        drive_in(1'b0, 32'd0);
        drive_bus(OTHER, 1'b0, 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_ready", 32'(bus_if.in_ready), 32'd1);
        check_eq("rst_oe", 32'(bus_if.bus_oe), 32'd0);
        check_eq("rst_rdata", bus_if.bus_rdata, 32'd0);
        check_eq("rst_underflow", 32'(underflow), 32'd0);

        // head word held over a multi-cycle read, consumed once
        drive_in(1'b1, 32'd5); step("t1_push");
        drive_in(1'b1, 32'd7); step("t1_push");
        drive_in(1'b1, 32'd9); step("t1_push");
        drive_in(1'b0, 32'd0);
        #1 check_eq("t1_count3", 32'(count), 32'd3);
        drive_bus(PORT, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("t1_head5", bus_if.bus_rdata, 32'd5);
            step("t1_hold");
        end
        drive_bus(OTHER, 1'b0, 32'd0);
        step("t1_leave");
        check_eq("t1_count2", 32'(count), 32'd2);
        drive_bus(PORT, 1'b0, 32'd0);
        #1 check_eq("t1_head7", bus_if.bus_rdata, 32'd7);
        drive_bus(OTHER, 1'b0, 32'd0);

        // full: no acceptance, ready returns after one read
        flush_fifo();
        push_words(DEPTH, 32'h1000);
        #1;
        check_eq("t2_full_ready", 32'(bus_if.in_ready), 32'd0);
        check_eq("t2_full_count", 32'(count), 32'd16);
        drive_in(1'b1, 32'hAA);
        step("t2_hold");
        check_eq("t2_still_full", 32'(count), 32'd16);
        read_episode(1);
        check_eq("t2_ready_back", 32'(bus_if.in_ready), 32'd1);
        step("t2_refill");
        drive_in(1'b0, 32'd0);

        // underflow, status word, clear
        flush_fifo();
        drive_bus(PORT, 1'b0, 32'd0);
        #1 check_eq("t3_empty_rdata", bus_if.bus_rdata, 32'd0);
        step("t3_read");
        drive_bus(OTHER, 1'b0, 32'd0);
        step("t3_leave");
        check_eq("t3_underflow", 32'(underflow), 32'd1);
        drive_bus(STAT, 1'b0, 32'd0);
        #1 check_eq("t3_status", bus_if.bus_rdata, 32'h0001_0000);
        step("t3_status");
        drive_bus(STAT, 1'b1, 32'd1);
        step("t3_clear");
        drive_bus(OTHER, 1'b0, 32'd0);
        #1 check_eq("t3_cleared", 32'(underflow), 32'd0);

        // simultaneous push/pop at count 4 through several pointer wraps
        flush_fifo();
        push_words(4, 32'd100);
        for (int i = 0; i < 36; i++) begin
            drive_in(1'b0, 32'd0);
            drive_bus(PORT, 1'b0, 32'd0);
            #1 check_eq("t4_order", bus_if.bus_rdata, 32'd100 + 32'(i));
            step("t4_read");
            drive_bus(OTHER, 1'b0, 32'd0);
            drive_in(1'b1, 32'd104 + 32'(i));
            step("t4_pushpop");
            check_eq("t4_count4", 32'(count), 32'd4);
        end
        drive_in(1'b0, 32'd0);

        // flush beats a same-cycle push
        drive_in(1'b1, 32'h33);
        drive_bus(STAT, 1'b1, 32'd2);
        step("t5_flush_push");
        drive_in(1'b0, 32'd0);
        drive_bus(OTHER, 1'b0, 32'd0);
        #1;
        check_eq("t5_count", 32'(count), 32'd0);
        check_eq("t5_ready", 32'(bus_if.in_ready), 32'd1);
        read_episode(1);
        check_eq("t5_underflow", 32'(underflow), 32'd1);
        drive_bus(STAT, 1'b1, 32'd1);
        step("t5_clear");
        drive_bus(OTHER, 1'b0, 32'd0);

        // reset in the middle of a read episode
        push_words(2, 32'h200);
        drive_bus(PORT, 1'b0, 32'd0);
        step("t6_hold");
        step("t6_hold");
        reset = 1'b1;
        model_reset();
        #1;
        check_eq("t6_rst_count", 32'(count), 32'd0);
        check_eq("t6_rst_underflow", 32'(underflow), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive_bus(OTHER, 1'b0, 32'd0);
        step("t6_release");
        check_eq("t6_count", 32'(count), 32'd0);
        check_eq("t6_no_underflow", 32'(underflow), 32'd0);

        // random mix of pushes, reads, status accesses and control writes
        for (int i = 0; i < 400; i++) begin
            int sel;
            drive_in(1'($urandom_range(0, 1)), $urandom);
            sel = $urandom_range(0, 11);
            if (sel < 4) drive_bus(PORT, 1'b0, $urandom);
            else if (sel < 7) drive_bus(OTHER, 1'($urandom_range(0, 1)), $urandom);
            else if (sel < 9) drive_bus(STAT, 1'b0, $urandom);
            else if (sel < 10) drive_bus(PORT, 1'b1, $urandom);
            else if (sel < 11) drive_bus(STAT, 1'b1, 32'($urandom_range(0, 1)));
            else drive_bus(STAT, 1'b1, 32'($urandom_range(0, 3)));
            step("rand");
        end
        drive_in(1'b0, 32'd0);
        drive_bus(OTHER, 1'b0, 32'd0);
        step("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
